// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected layer: FSM states,
// accumulator sizing and signed saturation.
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        FIN,
        OUT
    } fc_state_t;

    localparam int unsigned SAT_W = 64;

    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned n_in);
        return 2 * dw + $clog2(n_in);
    endfunction

    // Clamp a wide signed value to the range of an ow-bit signed number.
    function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] x,
                                                          input int unsigned ow);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/fc_layer_if.sv
// Streaming activation/weight input and packed result output of fc_layer.
interface fc_layer_if #(
    parameter int unsigned DW    = 16,
    parameter int unsigned N_OUT = 10,
    parameter int unsigned OW    = 18
);
    logic signed [DW-1:0]   din;
    logic [N_OUT*DW-1:0]    weight_in;
    logic [N_OUT*DW-1:0]    bias_in;
    logic                   in_valid;
    logic                   in_ready;
    logic [N_OUT*OW-1:0]    dout;
    logic                   out_valid;
    logic                   out_ready;
    logic                   fc_finish;

    modport master (
        output din, weight_in, bias_in, in_valid, out_ready,
        input  in_ready, dout, out_valid, fc_finish
    );

    modport slave (
        input  din, weight_in, bias_in, in_valid, out_ready,
        output in_ready, dout, out_valid, fc_finish
    );
endinterface

// File: rtl/fc_pe.sv
// One output channel: multiply-accumulate over the frame, then bias, rescale,
// saturate and optional ReLU into a registered result.
module fc_pe
    import fc_pkg::*;
#(
    parameter int unsigned DW   = 16,
    parameter int unsigned FRAC = 8,
    parameter int unsigned N_IN = 84,
    parameter int unsigned OW   = 18,
    parameter int unsigned RELU = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 acc_en,
    input  logic                 fin,
    input  logic signed [DW-1:0] din,
    input  logic signed [DW-1:0] weight,
    input  logic signed [DW-1:0] bias,
    output logic signed [OW-1:0] dout
);
    localparam int unsigned ACC_W = acc_width(DW, N_IN);
    localparam int unsigned S_W   = ACC_W + 1;

    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc;
    logic signed [S_W-1:0]   s;
    logic signed [S_W-1:0]   r;
    logic signed [SAT_W-1:0] sat;
    logic signed [OW-1:0]    res;

    always_comb begin
        prod     = (2*DW)'(din) * (2*DW)'(weight);
        prod_ext = ACC_W'(prod);
        s        = S_W'(acc) + (S_W'(bias) <<< FRAC);
        r        = s >>> FRAC;
        sat      = saturate(SAT_W'(r), OW);
        res      = sat[OW-1:0];
        if (RELU != 0 && res[OW-1]) res = '0;
    end

    // The first beat of a frame overwrites the accumulator instead of adding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc  <= '0;
            dout <= '0;
        end else begin
            if (acc_en) acc <= load ? prod_ext : acc + prod_ext;
            if (fin)    dout <= res;
        end
    end
endmodule

// File: rtl/fc_layer.sv
// Fully-connected layer: frame FSM, beat counter and handshake around N_OUT
// parallel accumulating channels.
module fc_layer
    import fc_pkg::*;
#(
    parameter int unsigned DW    = 16,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned N_IN  = 84,
    parameter int unsigned N_OUT = 10,
    parameter int unsigned OW    = 18,
    parameter int unsigned RELU  = 0
) (
    input  logic       clk,
    input  logic       reset,
    fc_layer_if.slave  bus
);
    localparam int unsigned CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    fc_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic                 beat;
    logic                 last;
    logic [N_OUT*OW-1:0]  dout_v;

    assign bus.in_ready = (state == IDLE) || (state == ACC);
    assign beat         = bus.in_valid && bus.in_ready;
    assign last         = (N_IN == 1) || (cnt == CNT_W'(N_IN - 1));
    assign bus.dout     = dout_v;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.fc_finish <= 1'b0;
        end else begin
            unique case (state)
                IDLE, ACC: begin
                    if (beat) begin
                        if (last) begin
                            state <= FIN;
                            cnt   <= '0;
                        end else begin
                            state <= ACC;
                            cnt   <= cnt + CNT_W'(1);
                        end
                    end
                end
                FIN: begin
                    state         <= OUT;
                    bus.out_valid <= 1'b1;
                    bus.fc_finish <= 1'b1;
                end
                OUT: begin
                    bus.fc_finish <= 1'b0;
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_pe
        fc_pe #(
            .DW   (DW),
            .FRAC (FRAC),
            .N_IN (N_IN),
            .OW   (OW),
            .RELU (RELU)
        ) u_pe (
            .clk    (clk),
            .reset  (reset),
            .load   (state == IDLE),
            .acc_en (beat),
            .fin    (state == FIN),
            .din    (bus.din),
            .weight (bus.weight_in[(N_OUT-1-k)*DW +: DW]),
            .bias   (bus.bias_in[(N_OUT-1-k)*DW +: DW]),
            .dout   (dout_v[(N_OUT-1-k)*OW +: OW])
        );
    end
endmodule

// File: tb/tb_fc_layer.sv
// Self-checking bench for fc_layer: four parameterisations share one stimulus
// bus, selected by sel, and are checked against an arithmetic reference.
module tb_fc_layer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int                  sel;
    logic signed [15:0]  din;
    logic                in_valid;
    logic                out_ready;
    logic [159:0]        w_all;
    logic [159:0]        b_all;
    logic [179:0]        dout_all;
    logic                out_valid;
    logic                in_ready;
    logic                fc_finish;

    int errors = 0;
    int checks = 0;

    int din_a[84];
    int w_a[84][10];
    int bias_a[10];

    fc_layer_if #(.DW(16), .N_OUT(2),  .OW(18)) if0 ();
    fc_layer_if #(.DW(16), .N_OUT(2),  .OW(18)) if1 ();
    fc_layer_if #(.DW(16), .N_OUT(2),  .OW(18)) if2 ();
    fc_layer_if #(.DW(16), .N_OUT(10), .OW(18)) if3 ();

    assign if0.din = din;  assign if0.weight_in = w_all[159 -: 32];  assign if0.bias_in = b_all[159 -: 32];
    assign if0.in_valid = in_valid && (sel == 0);  assign if0.out_ready = out_ready && (sel == 0);
    assign if1.din = din;  assign if1.weight_in = w_all[159 -: 32];  assign if1.bias_in = b_all[159 -: 32];
    assign if1.in_valid = in_valid && (sel == 1);  assign if1.out_ready = out_ready && (sel == 1);
    assign if2.din = din;  assign if2.weight_in = w_all[159 -: 32];  assign if2.bias_in = b_all[159 -: 32];
    assign if2.in_valid = in_valid && (sel == 2);  assign if2.out_ready = out_ready && (sel == 2);
    assign if3.din = din;  assign if3.weight_in = w_all;             assign if3.bias_in = b_all;
    assign if3.in_valid = in_valid && (sel == 3);  assign if3.out_ready = out_ready && (sel == 3);

    fc_layer #(.DW(16), .FRAC(8), .N_IN(3),  .N_OUT(2),  .OW(18), .RELU(0)) u0 (.clk(clk), .reset(reset), .bus(if0));
    fc_layer #(.DW(16), .FRAC(8), .N_IN(3),  .N_OUT(2),  .OW(18), .RELU(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
    fc_layer #(.DW(16), .FRAC(8), .N_IN(1),  .N_OUT(2),  .OW(18), .RELU(0)) u2 (.clk(clk), .reset(reset), .bus(if2));
    fc_layer #(.DW(16), .FRAC(8), .N_IN(84), .N_OUT(10), .OW(18), .RELU(0)) u3 (.clk(clk), .reset(reset), .bus(if3));

    always_comb begin
        dout_all  = '0;
        out_valid = 1'b0;
        in_ready  = 1'b0;
        fc_finish = 1'b0;
        case (sel)
            0: begin dout_all = {if0.dout, 144'b0}; out_valid = if0.out_valid; in_ready = if0.in_ready; fc_finish = if0.fc_finish; end
            1: begin dout_all = {if1.dout, 144'b0}; out_valid = if1.out_valid; in_ready = if1.in_ready; fc_finish = if1.fc_finish; end
            2: begin dout_all = {if2.dout, 144'b0}; out_valid = if2.out_valid; in_ready = if2.in_ready; fc_finish = if2.fc_finish; end
            default: begin dout_all = if3.dout; out_valid = if3.out_valid; in_ready = if3.in_ready; fc_finish = if3.fc_finish; end
        endcase
    end

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic longint chan(input int k);
        logic signed [17:0] v;
        v = dout_all[(9-k)*18 +: 18];
        return longint'(v);
    endfunction

    // Reference: exact integer dot product, bias scaled by 2^8, floor division
    // by 2^8, clamp to 18-bit signed, optional rectification.
    function automatic longint ref_out(input int n, input int k, input bit relu);
        longint sum;
        longint r;
        sum = 0;
        for (int i = 0; i < n; i++) sum += longint'(din_a[i]) * longint'(w_a[i][k]);
        sum += longint'(bias_a[k]) * 256;
        r = sum >>> 8;
        if (r > 131071)  r = 131071;
        if (r < -131072) r = -131072;
        if (relu && r < 0) r = 0;
        return r;
    endfunction

    task automatic pack(input int i);
        for (int k = 0; k < 10; k++) begin
            w_all[(9-k)*16 +: 16] = w_a[i][k][15:0];
            b_all[(9-k)*16 +: 16] = bias_a[k][15:0];
        end
        din = din_a[i][15:0];
    endtask

    task automatic load_const(input int n, input int d, input int w0, input int w1, input int b0, input int b1);
        for (int i = 0; i < n; i++) begin
            din_a[i] = d;
            for (int k = 0; k < 10; k++) w_a[i][k] = 0;
            w_a[i][0] = w0;
            w_a[i][1] = w1;
        end
        for (int k = 0; k < 10; k++) bias_a[k] = 0;
        bias_a[0] = b0;
        bias_a[1] = b1;
    endtask

    task automatic rand_fill(input int n, input int md, input int mw, input int mb);
        for (int i = 0; i < n; i++) begin
            din_a[i] = int'($urandom_range(0, 2*md - 1)) - md;
            for (int k = 0; k < 10; k++) w_a[i][k] = int'($urandom_range(0, 2*mw - 1)) - mw;
        end
        for (int k = 0; k < 10; k++) bias_a[k] = int'($urandom_range(0, 2*mb - 1)) - mb;
    endtask

    task automatic drive_frame(input int n, input bit gaps);
        int t;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            pack(i);
            in_valid = 1'b1;
            t = 0;
            while (!in_ready && t < 200) begin
                @(posedge clk); #1;
                t++;
            end
            if (!in_ready) check("in_ready_timeout", 0, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(output longint got[10], output int fin_cnt);
        int t;
        t = 0;
        fin_cnt = 0;
        for (int k = 0; k < 10; k++) got[k] = 0;
        while (!out_valid && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (!out_valid) begin
            check("out_valid_timeout", 0, 1);
            return;
        end
        for (int k = 0; k < 10; k++) got[k] = chan(k);
        fin_cnt = int'(fc_finish);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        fin_cnt += int'(fc_finish);
    endtask

    task automatic run_model(input int s, input int n, input bit relu, input int nout, input bit gaps, input string tag);
        longint got[10];
        int     fc;
        sel = s;
        drive_frame(n, gaps);
        collect(got, fc);
        for (int k = 0; k < nout; k++)
            check($sformatf("%s_ch%0d", tag, k), got[k], ref_out(n, k, relu));
        check($sformatf("%s_finish_pulses", tag), fc, 1);
    endtask

    typedef struct {
        int     dut;
        int     n;
        int     d;
        int     w0;
        int     w1;
        int     b0;
        int     b1;
        longint e0;
        longint e1;
    } vec_t;

    vec_t   tbl[6];
    longint got[10];
    int     fc;
    longint held;

    initial begin
        tbl[0] = '{0, 3, 256,   256,   -256,   0,   0,   768,    -768};
        tbl[1] = '{0, 3, 256,   256,   -256,   256, 512, 1024,   -256};
        tbl[2] = '{0, 3, 32767, 32767, -32768, 0,   0,   131071, -131072};
        tbl[3] = '{1, 3, 32767, 32767, -32768, 0,   0,   131071, 0};
        tbl[4] = '{0, 3, 1,     1,     -1,     0,   0,   0,      -1};
        tbl[5] = '{2, 1, 256,   256,   -256,   0,   0,   256,    -256};

        sel = 0; din = '0; in_valid = 1'b0; out_ready = 1'b0; w_all = '0; b_all = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_fc_finish", fc_finish, 0);
        check("rst_dout", (dout_all == '0), 1);
        reset = 1'b1;
        check("rst_in_ready", in_ready, 1);
        sel = 3;
        check("rst_dout_wide", (dout_all == '0), 1);

        for (int i = 0; i < 6; i++) begin
            sel = tbl[i].dut;
            load_const(tbl[i].n, tbl[i].d, tbl[i].w0, tbl[i].w1, tbl[i].b0, tbl[i].b1);
            drive_frame(tbl[i].n, 1'b0);
            collect(got, fc);
            check($sformatf("vec%0d_ch0", i), got[0], tbl[i].e0);
            check($sformatf("vec%0d_ch1", i), got[1], tbl[i].e1);
            check($sformatf("vec%0d_finish", i), fc, 1);
        end

        // Latency with out_ready held high: out_valid two edges after last beat, OUT lasts one cycle.
        sel = 0;
        load_const(3, 256, 256, -256, 0, 0);
        out_ready = 1'b1;
        drive_frame(3, 1'b0);
        check("lat_fin_valid", out_valid, 0);
        check("lat_fin_ready", in_ready, 0);
        @(posedge clk); #1;
        check("lat_out_valid", out_valid, 1);
        check("lat_finish", fc_finish, 1);
        check("lat_ch0", chan(0), 768);
        @(posedge clk); #1;
        check("lat_out_done", out_valid, 0);
        check("lat_finish_low", fc_finish, 0);
        check("lat_ready_back", in_ready, 1);
        out_ready = 1'b0;

        // Stalled input mid-frame must give the gap-free result.
        for (int f = 0; f < 3; f++) begin
            rand_fill(3, 4096, 4096, 2048);
            run_model(0, 3, 1'b0, 2, 1'b0, $sformatf("nogap%0d", f));
            run_model(0, 3, 1'b0, 2, 1'b1, $sformatf("gap%0d", f));
        end

        // Consumer back-pressure, then a new frame on the cycle after the handshake.
        load_const(3, 256, 256, -256, 0, 0);
        drive_frame(3, 1'b0);
        @(posedge clk); #1;
        check("bp_valid", out_valid, 1);
        held = chan(0);
        check("bp_first", held, 768);
        for (int c = 0; c < 5; c++) begin
            din = 16'sd100;
            in_valid = 1'b1;
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d", c), chan(0), 768);
            check($sformatf("bp_ready%0d", c), in_ready, 0);
            check($sformatf("bp_valid%0d", c), out_valid, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("b2b_ready", in_ready, 1);
        load_const(3, 256, 256, -256, 256, 512);
        drive_frame(3, 1'b0);
        @(posedge clk); #1;
        check("b2b_valid", out_valid, 1);
        collect(got, fc);
        check("b2b_ch0", got[0], 1024);
        check("b2b_ch1", got[1], -256);

        // Reset in the middle of a frame discards it entirely.
        load_const(3, 30000, 20000, -20000, 100, 100);
        drive_frame(2, 1'b0);
        reset = 1'b0;
        #1;
        check("mid_rst_dout", (dout_all == '0), 1);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_finish", fc_finish, 0);
        check("mid_rst_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        load_const(3, 256, 256, -256, 0, 0);
        drive_frame(3, 1'b0);
        collect(got, fc);
        check("post_rst_ch0", got[0], 768);
        check("post_rst_ch1", got[1], -768);
        check("post_rst_finish", fc, 1);

        // Random frames across parameterisations.
        for (int f = 0; f < 2; f++) begin
            rand_fill(3, 32768, 32768, 32768);
            run_model(0, 3, 1'b0, 2, 1'b1, $sformatf("r0_%0d", f));
            rand_fill(3, 2048, 2048, 4096);
            run_model(1, 3, 1'b1, 2, 1'b0, $sformatf("r1_%0d", f));
        end
        for (int f = 0; f < 4; f++) begin
            rand_fill(1, 32768, 32768, 32768);
            run_model(2, 1, 1'b0, 2, 1'b0, $sformatf("n1_%0d", f));
        end
        rand_fill(84, 1024, 512, 256);
        run_model(3, 84, 1'b0, 10, 1'b0, "w84_a");
        rand_fill(84, 32768, 32768, 32768);
        run_model(3, 84, 1'b0, 10, 1'b1, "w84_b");
        rand_fill(84, 4096, 4096, 8192);
        run_model(3, 84, 1'b0, 10, 1'b1, "w84_c");
        rand_fill(84, 8192, 1024, 32768);
        run_model(3, 84, 1'b0, 10, 1'b0, "w84_d");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fc_layer.md
# fc_layer

Parametrised fully-connected layer for the LeNet inference pipeline. It accumulates `N_IN` streamed activations against `N_OUT` per-channel weights in parallel, adds a per-channel bias, and rescales, saturates and optionally rectifies each channel. It presents all channel results as one packed vector under a valid/ready handshake. It sits after the last pooling/flatten stage and serves any FC layer (120→84, 84→10) by parameter choice; biases are runtime inputs, not constants.

## Interface
- `DW`, 16: activation/weight/bias width, signed fixed-point
- `FRAC`, 8: fractional bits of `din`, weights and bias
- `N_IN`, 84: activations per frame
- `N_OUT`, 10: output channels (parallel PEs)
- `OW`, 18: output width per channel, signed
- `RELU`, 0: 1 = clamp negative results to 0
- `clk  input  1`: clock, rising edge
- `reset  input  1`: asynchronous, active-low reset
- `din  input  DW`: activation, signed
- `weight_in  input  N_OUT*DW`: weights for current beat; channel 0 in MSBs
- `bias_in  input  N_OUT*DW`: biases; channel 0 in MSBs; sampled in FIN only
- `in_valid  input  1`: `din`/`weight_in` valid
- `in_ready  output  1`: beat accepted when `in_valid && in_ready`
- `dout  output  N_OUT*OW`: results; channel 0 in MSBs
- `out_valid  output  1`: `dout` valid
- `out_ready  input  1`: consumer takes frame when `out_valid && out_ready`
- `fc_finish  output  1`: one-cycle pulse on the first cycle of `out_valid`

## Operation
- States:
  - IDLE→ACC on first accepted beat.
  - ACC→FIN on the accepted beat with `cnt == N_IN-1`.
  - FIN→OUT unconditionally.
  - OUT→IDLE on `out_valid && out_ready`.
- Frame start: accumulators are loaded with the first product. There is no separate clear cycle.
- Accumulator width is `ACC_W = 2*DW + clog2(N_IN)`. Each beat does `acc[k] += din * w[k]` as a full-precision signed product, sign-extended.
- `cnt` counts accepted beats, 0..N_IN-1, and wraps to 0 on entering FIN.
- In FIN, per channel:
  - `s = acc + (bias << FRAC)`
  - `r = s >>> FRAC`, arithmetic shift, truncating toward −∞
  - saturate `r` to [−2^(OW−1), 2^(OW−1)−1]
  - if `RELU`, negative results become 0
  - register into `dout`
- `in_ready` = 1 in IDLE and ACC, 0 in FIN and OUT. No new frame is accepted until the result is taken.
- `dout` holds stable while `out_valid` = 1 and `out_ready` = 0.
- `in_valid` low inside ACC stalls the frame: accumulators and `cnt` hold.
- Reset values: state IDLE, `cnt` 0, all accumulators 0, `dout` 0, `out_valid` 0, `fc_finish` 0. `in_ready` reads 1 as soon as reset deasserts.
- Reset asserted mid-frame discards the partial frame. The next accepted beat is beat 0.

## Timing
- Beat throughput: 1 per cycle in ACC.
- Latency: last beat accepted at edge t → FIN during cycle t..t+1 → `out_valid` and `fc_finish` high after edge t+1.
- Back-to-back frames:
  - Earliest next first beat is the cycle after the `out_valid && out_ready` handshake.
  - Frame period is at least `N_IN + 2` cycles.
- `N_IN == 1`: the first beat goes IDLE→FIN directly.
- `out_ready` may be held high permanently. The OUT state then lasts exactly 1 cycle.

## Structure
- Package `fc_pkg`:
  - state enum (IDLE, ACC, FIN, OUT)
  - `acc_width(dw, n_in)` function
  - saturation helper function
- Sub-module `fc_pe`, one per channel. It holds one accumulator and the FIN-stage bias/shift/saturate/ReLU logic.
- The top level (`fc_layer`) owns the FSM, `cnt`, the handshake and the pack/unpack of the vectors.

## Test plan
Unless noted: `N_IN=3`, `N_OUT=2`, `DW=16`, `FRAC=8`, `OW=18`.
- Nominal: three beats `din=256`, w0=256, w1=−256, bias 0 → ch0=768, ch1=−768; `out_valid` two edges after last beat; one `fc_finish` pulse.
- Bias: as nominal, bias0=256, bias1=512 → ch0=1024, ch1=−256.
- Saturation and ReLU:
  - `din=32767`, `w=32767` all beats → ch0 = 131071.
  - `w=−32768` → −131072.
  - Repeat with `RELU=1` → ch1 = 0.
- Handshake:
  - Gaps in `in_valid` mid-frame → same results as gap-free.
  - `out_ready=0` for 5 cycles → `dout` stable and `in_ready=0` throughout.
  - New frame accepted the cycle after the handshake.
- Reset mid-frame: after 2 beats assert `reset` → all outputs 0. A fresh 3-beat frame gives the nominal results, with no residue from the aborted frame.
- Parameter sweep: `N_IN=1`, and `N_IN=84` with `N_OUT=10`, random vectors checked against a bit-exact reference model.
